instr_loader: RTL

Program loader for the jacaranda-8 core: accepts decoded instruction fields (opcode, rd, rs, imm) over a valid/ready stream and packs each set into an 8-bit instruction word. The packing is the exact inverse of the core's field split. It writes the packed words into instruction memory at sequential addresses and holds the core off while loading. It sits between the host/debug interface and the instruction-memory write port.

---
 rtl/jacaranda_pkg.sv | 26 ++
 rtl/instr_loader_if.sv | 29 ++
 rtl/instr_loader_encoder.sv | 26 ++
 rtl/instr_loader.sv | 102 ++++++++++
 4 files changed

// File: rtl/jacaranda_pkg.sv
// Shared jacaranda-8 definitions: instruction field layout, format codes and
// loader state encoding. The core's field-split logic uses the same constants.
package jacaranda_pkg;

  localparam int LD_ADDR_W = 8;
  localparam int WORD_W    = 8;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic FMT_REG = 1'b0;
  localparam logic FMT_IMM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } ld_state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Loader bus: decoded-field valid/ready stream in, instruction-memory write port out.
// master = host / memory side, slave = the loader.
interface instr_loader_if
  import jacaranda_pkg::*;
#(
  parameter int ADDR_W = LD_ADDR_W
);
  logic                       valid;
  logic                       ready;
  logic                       fmt;
  logic [OPC_MSB-OPC_LSB:0]   opcode;
  logic [RD_MSB-RD_LSB:0]     rd;
  logic [RS_MSB-RS_LSB:0]     rs;
  logic [IMM_MSB-IMM_LSB:0]   imm;
  logic                       we;
  logic [ADDR_W-1:0]          addr;
  logic [WORD_W-1:0]          wdata;

  modport master (
    output valid, fmt, opcode, rd, rs, imm,
    input  ready, we, addr, wdata
  );

  modport slave (
    input  valid, fmt, opcode, rd, rs, imm,
    output ready, we, addr, wdata
  );

endinterface

// File: rtl/instr_loader_encoder.sv
// Combinational packer: instruction fields to an 8-bit jacaranda-8 word,
// the exact inverse of the core's field split.
module instr_encoder
  import jacaranda_pkg::*;
(
  input  logic                     i_fmt,
  input  logic [OPC_MSB-OPC_LSB:0] i_opcode,
  input  logic [RD_MSB-RD_LSB:0]   i_rd,
  input  logic [RS_MSB-RS_LSB:0]   i_rs,
  input  logic [IMM_MSB-IMM_LSB:0] i_imm,
  output logic [WORD_W-1:0]        o_word
);

  always_comb begin
    o_word                  = '0;
    o_word[OPC_MSB:OPC_LSB] = i_opcode;
    // immediate overlays the rd/rs bit positions
    if (i_fmt == FMT_IMM) begin
      o_word[IMM_MSB:IMM_LSB] = i_imm;
    end else begin
      o_word[RD_MSB:RD_LSB] = i_rd;
      o_word[RS_MSB:RS_LSB] = i_rs;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Program loader: packs field sets and writes them to instruction memory at
// sequential (wrapping) addresses while holding the core.
//   state     | meaning
//   ST_IDLE   | waiting for start; stream not ready
//   ST_LOAD   | accepting beats until remaining reaches 0
//   ST_FINISH | one-cycle done pulse, then back to idle
module instr_loader
  import jacaranda_pkg::*;
#(
  parameter int ADDR_W = LD_ADDR_W
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_count,
  input  logic              i_abort,
  instr_loader_if.slave     bus,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic [WORD_W-1:0] o_checksum
);

  ld_state_e         r_state;
  ld_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic [WORD_W-1:0] r_checksum;
  logic [WORD_W-1:0] w_word;
  logic              w_ready;
  logic              w_beat;

  instr_encoder u_enc (
    .i_fmt    (bus.fmt),
    .i_opcode (bus.opcode),
    .i_rd     (bus.rd),
    .i_rs     (bus.rs),
    .i_imm    (bus.imm),
    .o_word   (w_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_beat      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = (i_count == '0) ? ST_FINISH : ST_LOAD;
      end
      ST_LOAD: begin
        w_ready = (r_remaining != '0);
        // a beat coinciding with abort is dropped
        w_beat  = bus.valid & w_ready & ~i_abort;
        if (i_abort) w_state_nxt = ST_IDLE;
        else if (w_beat && r_remaining == (ADDR_W+1)'(1)) w_state_nxt = ST_FINISH;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_checksum  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= w_beat;
      if (r_state == ST_IDLE && i_start) begin
        r_wr_ptr    <= i_base_addr;
        r_remaining <= i_count;
        r_checksum  <= '0;
      end
      if (w_beat) begin
        r_mem_addr  <= r_wr_ptr;
        r_mem_wdata <= w_word;
        r_checksum  <= r_checksum ^ w_word;
        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - (ADDR_W+1)'(1);
      end
    end
  end

  assign bus.ready  = w_ready;
  assign bus.we     = r_mem_we;
  assign bus.addr   = r_mem_addr;
  assign bus.wdata  = r_mem_wdata;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_cpu_hold = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_FINISH) & ~i_abort;
  assign o_checksum = r_checksum;

endmodule
